// File: rtl/cnu_c2v_expander_if.sv
// Record-in / per-edge-message-out handshake bundle for the C2V expander.
// Master drives records and consumes messages; slave is the expander itself.
// Sign-recovery ports exist only when CNU_SIGN_RECOVER_EN is defined.
interface cnu_c2v_expander_if #(
   parameter int CN_DEGREE          = 6,
   parameter int QUAN_SIZE          = 3,
   parameter int MIN_INDEX_BITWIDTH = $clog2(CN_DEGREE)
);
   logic                          in_valid;
   logic                          in_ready;
   logic [QUAN_SIZE-1:0]          in_m1;
   logic [QUAN_SIZE-1:0]          in_m2;
   logic [MIN_INDEX_BITWIDTH-1:0] in_min_1_index;
   logic                          out_valid;
   logic                          out_ready;
   logic [QUAN_SIZE-1:0]          out_msg;
   logic [MIN_INDEX_BITWIDTH-1:0] out_edge;
   logic                          out_last;
`ifdef CNU_SIGN_RECOVER_EN
   logic [CN_DEGREE-1:0]          in_sign_vec;
   logic                          out_sign;
`endif

   modport master (
      output in_valid, in_m1, in_m2, in_min_1_index, out_ready,
`ifdef CNU_SIGN_RECOVER_EN
      output in_sign_vec,
      input  out_sign,
`endif
      input  in_ready, out_valid, out_msg, out_edge, out_last
   );

   modport slave (
      input  in_valid, in_m1, in_m2, in_min_1_index, out_ready,
`ifdef CNU_SIGN_RECOVER_EN
      input  in_sign_vec,
      output out_sign,
`endif
      output in_ready, out_valid, out_msg, out_edge, out_last
   );
endinterface

// File: rtl/cnu_c2v_expander.sv
// Expands one compressed check-node record (min1, min2, min1 index) into CN_DEGREE C2V messages, one edge per beat.
// Latency: record accepted in cycle N -> edge 0 valid in cycle N+1; CN_DEGREE cycles per record back-to-back.
// Backpressure: out_ready low freezes the current beat; in_ready is combinational from out_ready on the last beat.
// Optional macro CNU_SIGN_RECOVER_EN adds per-edge sign recovery (in_sign_vec / out_sign).
module cnu_c2v_expander #(
   parameter int CN_DEGREE          = 6,
   parameter int QUAN_SIZE          = 3,
   parameter int MIN_INDEX_BITWIDTH = $clog2(CN_DEGREE)
) (
   input  logic              sys_clk,
   input  logic              rstn,
   cnu_c2v_expander_if.slave bus,
   output logic              busy
);
   localparam logic [MIN_INDEX_BITWIDTH-1:0] LAST_EDGE = MIN_INDEX_BITWIDTH'(CN_DEGREE - 1);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                        state, state_nxt;
   logic [QUAN_SIZE-1:0]          held_m1;
   logic [QUAN_SIZE-1:0]          held_m2;
   logic [MIN_INDEX_BITWIDTH-1:0] held_index;
   logic [MIN_INDEX_BITWIDTH-1:0] edge_nxt;
   logic                          fire;
   logic                          load;
`ifdef CNU_SIGN_RECOVER_EN
   logic [CN_DEGREE-1:0]          held_sign;
   logic                          held_parity;
`endif

   // out_edge doubles as the edge counter; it never advances past the last edge
   assign fire         = bus.out_valid && bus.out_ready;
   assign bus.in_ready = (state == IDLE) || ((state == EMIT) && bus.out_last && bus.out_ready);
   assign load         = bus.in_valid && bus.in_ready;
   assign edge_nxt     = bus.out_edge + 1'b1;
   assign busy         = (state == EMIT);

   // state register
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state: leave EMIT only after the last beat is taken with no record waiting
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = EMIT;
         EMIT:    if (fire && bus.out_last && !bus.in_valid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // held record and registered beat outputs; a new record overrides advancing the current one
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         held_m1       <= '0;
         held_m2       <= '0;
         held_index    <= '0;
         bus.out_valid <= 1'b0;
         bus.out_msg   <= '0;
         bus.out_edge  <= '0;
         bus.out_last  <= 1'b0;
`ifdef CNU_SIGN_RECOVER_EN
         held_sign     <= '0;
         held_parity   <= 1'b0;
         bus.out_sign  <= 1'b0;
`endif
      end else begin
         bus.out_valid <= (state_nxt == EMIT);
         if (load) begin
            held_m1      <= bus.in_m1;
            held_m2      <= bus.in_m2;
            held_index   <= bus.in_min_1_index;
            bus.out_edge <= '0;
            bus.out_msg  <= (bus.in_min_1_index == '0) ? bus.in_m2 : bus.in_m1;
            bus.out_last <= 1'b0;
`ifdef CNU_SIGN_RECOVER_EN
            held_sign    <= bus.in_sign_vec;
            held_parity  <= ^bus.in_sign_vec;
            bus.out_sign <= (^bus.in_sign_vec) ^ bus.in_sign_vec[0];
`else
            // magnitude-only build: no sign state to capture
`endif
         end else if (fire && !bus.out_last) begin
            bus.out_edge <= edge_nxt;
            bus.out_msg  <= (edge_nxt == held_index) ? held_m2 : held_m1;
            bus.out_last <= (edge_nxt == LAST_EDGE);
`ifdef CNU_SIGN_RECOVER_EN
            bus.out_sign <= held_parity ^ held_sign[edge_nxt];
`endif
         end
      end
   end
endmodule

// File: tb/tb_cnu_c2v_expander.sv
// Self-checking bench for cnu_c2v_expander: directed scenarios then randomized records and backpressure.
// Expected beats come from a per-record queue model built from the expansion rules.
// Outputs are sampled on the falling edge; inputs change 1 ns after the rising edge.
module tb_cnu_c2v_expander;
   localparam int D = 6;
   localparam int Q = 3;
   localparam int W = $clog2(D);

   typedef struct {
      int edg;
      int msg;
      bit last;
      bit sign;
   } beat_t;

   logic  sys_clk = 1'b0;
   logic  rstn    = 1'b0;
   logic  busy;
   int    n_tests = 0;
   int    n_fail  = 0;
   beat_t q[$];
   beat_t b;
   bit    exp_rdy;
   bit    took;

   cnu_c2v_expander_if #(.CN_DEGREE(D), .QUAN_SIZE(Q)) bus ();

   cnu_c2v_expander #(.CN_DEGREE(D), .QUAN_SIZE(Q)) dut (
      .sys_clk (sys_clk),
      .rstn    (rstn),
      .bus     (bus),
      .busy    (busy)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: every accepted record becomes D expected beats
   always @(negedge sys_clk) begin
      if (!rstn) begin
         q.delete();
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_in_ready", bus.in_ready, 1);
         chk("rst_out_msg", bus.out_msg, 0);
         chk("rst_out_edge", bus.out_edge, 0);
         chk("rst_out_last", bus.out_last, 0);
         chk("rst_busy", busy, 0);
`ifdef CNU_SIGN_RECOVER_EN
         chk("rst_out_sign", bus.out_sign, 0);
`endif
      end else begin
         exp_rdy = (q.size() == 0) || (q.size() == 1 && bus.out_ready);
         chk("in_ready", bus.in_ready, exp_rdy);
         chk("busy", busy, q.size() > 0);
         if (q.size() > 0) begin
            chk("out_valid", bus.out_valid, 1);
            chk("out_edge", bus.out_edge, q[0].edg);
            chk("out_msg", bus.out_msg, q[0].msg);
            chk("out_last", bus.out_last, q[0].last);
`ifdef CNU_SIGN_RECOVER_EN
            chk("out_sign", bus.out_sign, q[0].sign);
`endif
            if (bus.out_ready) void'(q.pop_front());
         end else begin
            chk("out_valid_idle", bus.out_valid, 0);
         end
         if (bus.in_valid && exp_rdy) begin
            for (int e = 0; e < D; e++) begin
               b.edg  = e;
               b.msg  = (e == int'(bus.in_min_1_index)) ? int'(bus.in_m2) : int'(bus.in_m1);
               b.last = (e == D - 1);
               b.sign = 1'b0;
`ifdef CNU_SIGN_RECOVER_EN
               b.sign = (^bus.in_sign_vec) ^ bus.in_sign_vec[e];
`endif
               q.push_back(b);
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic set_rec(input int m1, input int m2, input int idx, input logic [D-1:0] sv);
      bus.in_m1          = Q'(m1);
      bus.in_m2          = Q'(m2);
      bus.in_min_1_index = W'(idx);
`ifdef CNU_SIGN_RECOVER_EN
      bus.in_sign_vec    = sv;
`else
      if (sv == '1) bus.in_min_1_index = W'(idx);
`endif
   endtask

   // offer one record and hold it until accepted, then drop in_valid
   task automatic send(input int m1, input int m2, input int idx, input logic [D-1:0] sv);
      bit ok;
      ok = 1'b0;
      set_rec(m1, m2, idx, sv);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge sys_clk);
         if (bus.in_ready) ok = 1'b1;
      end
      if (!ok) chk("send_timeout", 0, 1);
      @(posedge sys_clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      set_rec(0, 0, 0, '0);
      cycles(3);
      rstn = 1'b1;
      cycles(2);

      // basic record, then an idle gap
      send(2, 5, 3, 6'b001011);
      cycles(8);

      // back-to-back: second record waits through the first one's last beat
      send(2, 5, 3, 6'b110100);
      send(1, 7, 0, 6'b101010);
      cycles(8);

      // backpressure on edge 2 for three cycles
      send(3, 6, 4, 6'b000001);
      cycles(2);
      bus.out_ready = 1'b0;
      cycles(3);
      bus.out_ready = 1'b1;
      cycles(6);

      // illegal index: all edges carry m1
      send(4, 6, 7, 6'b111111);
      cycles(8);

      // reset while edge 3 is on the bus
      send(5, 1, 2, 6'b011001);
      cycles(3);
      rstn = 1'b0;
      #2;
      chk("async_rst_out_valid", bus.out_valid, 0);
      chk("async_rst_in_ready", bus.in_ready, 1);
      cycles(2);
      rstn = 1'b1;
      cycles(4);
      send(6, 2, 5, 6'b100110);
      cycles(8);

      // randomized records, gaps and backpressure
      for (int c = 0; c < 3000; c++) begin
         @(negedge sys_clk);
         took = bus.in_valid && bus.in_ready;
         @(posedge sys_clk);
         #1;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (took || !bus.in_valid) begin
            bus.in_valid = ($urandom_range(0, 2) != 0);
            set_rec($urandom_range(0, (1 << Q) - 1), $urandom_range(0, (1 << Q) - 1),
                    $urandom_range(0, (1 << W) - 1), D'($urandom));
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      cycles(2 * D);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end
endmodule
